// File: rtl/register_scoreboard.sv
// Register scoreboard: per-register pending-write counters between issue and writeback.
// Stalls issue on RAW hazards and on destination counter saturation.
module register_scoreboard #(
  parameter int unsigned MaxPending = 3,
  parameter bit          WbBypass   = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [4:0]  issue_rs1_i,
  input  logic [4:0]  issue_rs2_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        issue_uses_rs1_i,
  input  logic        issue_uses_rs2_i,
  input  logic        issue_writes_rd_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  output logic [31:0] busy_o,
  output logic [15:0] stall_cycles_o,
  output logic        underflow_err_o
);

  localparam int unsigned CntW = $clog2(MaxPending + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MaxPending);
  localparam cnt_t CntOne = cnt_t'(1);

  cnt_t        cnt_q [32];
  cnt_t        cnt_d [32];
  logic [31:0] wb_hit;
  logic [31:0] issue_inc;
  logic [31:0] busy_d, busy_q;
  logic [15:0] stall_d, stall_q;
  logic        uf_d, uf_q;
  logic        rs1_haz, rs2_haz, rd_haz;
  logic        issue_fire;

  always_comb begin
    wb_hit = '0;
    for (int unsigned n = 1; n < 32; n++) begin
      wb_hit[n] = wb_valid_i && (wb_rd_i == 5'(n)) && (cnt_q[n] != '0);
    end
  end

  // A source whose only pending write retires this cycle is forwarded by writeback.
  always_comb begin
    rs1_haz = issue_uses_rs1_i && (issue_rs1_i != 5'd0) && (cnt_q[issue_rs1_i] != '0) &&
              !(WbBypass && (cnt_q[issue_rs1_i] == CntOne) && wb_hit[issue_rs1_i]);
    rs2_haz = issue_uses_rs2_i && (issue_rs2_i != 5'd0) && (cnt_q[issue_rs2_i] != '0) &&
              !(WbBypass && (cnt_q[issue_rs2_i] == CntOne) && wb_hit[issue_rs2_i]);
    rd_haz  = issue_writes_rd_i && (issue_rd_i != 5'd0) && (cnt_q[issue_rd_i] == CntMax) &&
              !wb_hit[issue_rd_i];
    issue_ready_o = !flush_i && !reset_i && !rs1_haz && !rs2_haz && !rd_haz;
    issue_fire    = issue_valid_i && issue_ready_o;
  end

  always_comb begin
    issue_inc = '0;
    for (int unsigned n = 1; n < 32; n++) begin
      issue_inc[n] = issue_fire && issue_writes_rd_i && (issue_rd_i == 5'(n));
    end
  end

  always_comb begin
    cnt_d[0]  = '0;
    busy_d    = '0;
    for (int unsigned n = 1; n < 32; n++) begin
      cnt_d[n] = cnt_q[n];
      if (flush_i) begin
        cnt_d[n] = '0;
      end else if (issue_inc[n] && wb_hit[n]) begin
        cnt_d[n] = cnt_q[n];
      end else if (issue_inc[n]) begin
        cnt_d[n] = cnt_q[n] + CntOne;
      end else if (wb_hit[n]) begin
        cnt_d[n] = cnt_q[n] - CntOne;
      end
      busy_d[n] = (cnt_d[n] != '0);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (issue_valid_i && !issue_ready_o && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    // Flushed writebacks are dropped entirely, so they cannot underflow.
    uf_d = uf_q | (wb_valid_i && !flush_i && (wb_rd_i != 5'd0) && (cnt_q[wb_rd_i] == '0));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned n = 0; n < 32; n++) begin
        cnt_q[n] <= '0;
      end
      busy_q  <= '0;
      stall_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < 32; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
      busy_q  <= busy_d;
      stall_q <= stall_d;
      uf_q    <= uf_d;
    end
  end

  assign busy_o          = busy_q;
  assign stall_cycles_o  = stall_q;
  assign underflow_err_o = uf_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Randomized and directed bench for register_scoreboard against a per-register count model.
module tb_register_scoreboard;

  localparam int MaxP = 3;
  localparam bit Byp  = 1'b1;

  logic        clk = 1'b0;
  logic        reset, flush, issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        issue_uses_rs1, issue_uses_rs2, issue_writes_rd, wb_valid;
  logic [31:0] busy;
  logic [15:0] stall_cycles;
  logic        underflow_err;

  always #5 clk = ~clk;

  register_scoreboard #(.MaxPending(MaxP), .WbBypass(Byp)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .flush_i          (flush),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_rs1_i      (issue_rs1),
    .issue_rs2_i      (issue_rs2),
    .issue_rd_i       (issue_rd),
    .issue_uses_rs1_i (issue_uses_rs1),
    .issue_uses_rs2_i (issue_uses_rs2),
    .issue_writes_rd_i(issue_writes_rd),
    .wb_valid_i       (wb_valid),
    .wb_rd_i          (wb_rd),
    .busy_o           (busy),
    .stall_cycles_o   (stall_cycles),
    .underflow_err_o  (underflow_err)
  );

  // Reference model: plain integer pending-write counts per architectural register.
  int m_cnt [32];
  int m_stall;
  bit m_uf;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit m_hit(input int r);
    return wb_valid && (int'(wb_rd) == r) && (r != 0) && (m_cnt[r] != 0);
  endfunction

  function automatic bit m_src_haz(input bit uses, input int r);
    if (!uses || r == 0 || m_cnt[r] == 0) return 1'b0;
    if (Byp && m_cnt[r] == 1 && m_hit(r)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    if (reset || flush) return 1'b0;
    if (m_src_haz(issue_uses_rs1, int'(issue_rs1))) return 1'b0;
    if (m_src_haz(issue_uses_rs2, int'(issue_rs2))) return 1'b0;
    if (issue_writes_rd && issue_rd != 0 && m_cnt[issue_rd] == MaxP && !m_hit(int'(issue_rd)))
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic m_update(input bit rdy);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_stall = 0;
      m_uf    = 1'b0;
      return;
    end
    if (issue_valid && !rdy && m_stall < 16'hFFFF) m_stall++;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      return;
    end
    if (wb_valid && wb_rd != 0) begin
      if (m_cnt[wb_rd] == 0) m_uf = 1'b1;
      else m_cnt[wb_rd]--;
    end
    if (issue_valid && rdy && issue_writes_rd && issue_rd != 0) m_cnt[issue_rd]++;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step(input string tag);
    bit er;
    #1;
    er = m_ready();
    check_eq({tag, "/ready"}, {31'd0, issue_ready}, {31'd0, er});
    @(posedge clk);
    m_update(er);
    #1;
    check_eq({tag, "/busy"}, busy, m_busy());
    check_eq({tag, "/stall"}, {16'd0, stall_cycles}, m_stall[31:0]);
    check_eq({tag, "/uf"}, {31'd0, underflow_err}, {31'd0, m_uf});
  endtask

  task automatic idle();
    reset = 0; flush = 0; issue_valid = 0; wb_valid = 0; wb_rd = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes_rd = 0;
  endtask

  task automatic put(input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wr);
    issue_valid = 1; issue_rs1 = 5'(rs1); issue_uses_rs1 = u1;
    issue_rs2 = 5'(rs2); issue_uses_rs2 = u2; issue_rd = 5'(rd); issue_writes_rd = wr;
  endtask

  task automatic do_reset();
    idle(); reset = 1; step("reset"); reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_stall = 0; m_uf = 0;
    idle();
    @(posedge clk); #1;
    reset = 1;
    #1;
    check_eq("ready_in_reset", {31'd0, issue_ready}, 32'd0);
    step("reset0"); reset = 0;
    check_eq("reset_busy", busy, 32'd0);

    // RAW on x5 with writeback bypass.
    put(0, 0, 0, 0, 5, 1); step("iss5");
    check_eq("busy_x5", busy, 32'h20);
    put(5, 1, 0, 0, 6, 0);
    repeat (3) step("raw5");
    check_eq("stall_raw5", {16'd0, stall_cycles}, 32'd3);
    wb_valid = 1; wb_rd = 5;
    #1;
    check_eq("bypass_ready", {31'd0, issue_ready}, 32'd1);
    step("wb5");
    check_eq("busy_after_wb5", busy, 32'd0);
    idle();

    // Saturate x7, then issue with a same-cycle writeback.
    put(0, 0, 0, 0, 7, 1);
    repeat (3) step("pend7");
    step("full7");
    wb_valid = 1; wb_rd = 7; step("full7_wb");
    check_eq("busy7_still", busy, 32'h80);
    idle(); wb_valid = 1; wb_rd = 7;
    repeat (2) step("drain7");
    check_eq("busy7_last", busy, 32'h80);
    step("drain7_last");
    check_eq("busy7_clear", busy, 32'd0);
    idle();

    // x0 is never tracked.
    for (int i = 0; i < 4; i++) begin put(0, 1, 0, 1, 0, 1); step("x0"); end
    check_eq("x0_busy", busy, 32'd0);
    idle();

    // Sticky underflow: survives flush, cleared by reset.
    wb_valid = 1; wb_rd = 9; step("uf9");
    check_eq("uf_set", {31'd0, underflow_err}, 32'd1);
    idle(); flush = 1; step("uf_flush");
    check_eq("uf_keep", {31'd0, underflow_err}, 32'd1);
    do_reset();
    check_eq("uf_clr", {31'd0, underflow_err}, 32'd0);

    // Flush clears pending state; flushed writeback is not an underflow.
    put(0, 0, 0, 0, 3, 1); step("p3");
    put(0, 0, 0, 0, 4, 1); step("p4");
    put(3, 1, 4, 1, 8, 1); flush = 1; wb_valid = 1; wb_rd = 3;
    step("flush");
    check_eq("flush_busy", busy, 32'd0);
    idle(); put(3, 1, 4, 1, 8, 1);
    #1;
    check_eq("post_flush_ready", {31'd0, issue_ready}, 32'd1);
    step("post_flush");
    do_reset();

    // Random traffic over a small register window to provoke hazards.
    for (int c = 0; c < 2000; c++) begin
      int cand;
      idle();
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) != 0)
        put($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
            $urandom_range(0, 7), 1'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        cand = $urandom_range(0, 7);
        if (m_cnt[cand] != 0 || $urandom_range(0, 15) == 0) begin
          wb_valid = 1; wb_rd = 5'(cand);
        end
      end
      step("rand");
    end

    // Long stall to saturate the counter.
    do_reset();
    put(0, 0, 0, 0, 5, 1); step("sat_p5");
    put(5, 1, 0, 0, 0, 0);
    repeat (70000) @(posedge clk);
    m_stall = (m_stall + 70000 > 16'hFFFF) ? 16'hFFFF : m_stall + 70000;
    #1;
    check_eq("stall_sat", {16'd0, stall_cycles}, 32'h0000FFFF);
    step("sat_hold");
    check_eq("stall_sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Tracks outstanding register-file writes between instruction issue and writeback, and stalls issue of any instruction whose source registers (rs1/rs2 from the immediate/register-field decoder) or destination register are not yet safe. Sits between decode and execute. Decode presents one decoded instruction per cycle with a valid/ready handshake. The writeback stage reports each retiring destination register.

## Interface
- `MAX_PENDING`, default 3: maximum outstanding writes tracked per register (1..7). Counter width is `$clog2(MAX_PENDING+1)`.
- `WB_BYPASS`, default 1: when 1, a same-cycle writeback that drains a source register's last pending write clears that source hazard combinationally.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard all pending writes (pipeline flush on branch/jump redirect).
- `issue_valid` in 1: decode presents an instruction.
- `issue_ready` out 1: scoreboard permits issue this cycle.
- `issue_rs1` in 5: first source register.
- `issue_rs2` in 5: second source register.
- `issue_rd` in 5: destination register.
- `issue_uses_rs1` in 1: instruction reads rs1.
- `issue_uses_rs2` in 1: instruction reads rs2.
- `issue_writes_rd` in 1: instruction writes rd.
- `wb_valid` in 1: a write retires this cycle.
- `wb_rd` in 5: register being written back.
- `busy` out 32: bit n = register n has ≥1 pending write; bit 0 always 0.
- `stall_cycles` out 16: saturating count of cycles with `issue_valid && !issue_ready`.
- `underflow_err` out 1: sticky; set by a writeback to a register with zero pending writes.

## Operation
- State is one counter `cnt[n]` per register n = 1..31. Register x0 has no counter, is never busy, and never causes a hazard; issue or writeback naming x0 is ignored.
- `wb_hit[n]` = `wb_valid && wb_rd==n && cnt[n]!=0`.
- A source hazard on rsX occurs when `issue_uses_rsX`, rsX≠0, and `cnt[rsX]!=0`. With `WB_BYPASS=1`, it is not a hazard if `cnt[rsX]==1 && wb_hit[rsX]`.
- A destination hazard occurs when `issue_writes_rd`, rd≠0, and `cnt[rd]==MAX_PENDING` with no `wb_hit[rd]`.
- `issue_ready` = `!flush && !reset && no hazard`.
- `issue_ready` depends only on current-cycle inputs and state. It does not depend on `issue_valid`.
- Issue fires on `issue_valid && issue_ready`.
- Per-register next count, applied in priority order:
  - `reset` or `flush`: 0.
  - Issue increments `cnt[rd]` (when it writes rd≠0) and `wb_hit` decrements the same register in the same cycle: unchanged.
  - Issue increments only: +1.
  - `wb_hit` only: −1.
  - Otherwise: hold.
- Writeback with `wb_valid`, `wb_rd`≠0 and `cnt==0`: counter stays 0 and `underflow_err` is set. It is cleared only by `reset`; `flush` does not clear it.
- While `flush` is high, writebacks are discarded, including for underflow checking.
- `stall_cycles` increments by 1 per stalled cycle and saturates at 16'hFFFF. It is cleared only by `reset`. Cycles in which `flush` is high count as stalls if `issue_valid` is high.
- `busy[n]` = `cnt[n]!=0`, registered (reflects post-edge state).

## Timing
- Reset values:
  - All counters 0.
  - `busy`=0, `stall_cycles`=0, `underflow_err`=0.
  - `issue_ready`=0 while `reset` is high.
- An issue accepted at edge k makes `busy[rd]` high after edge k.
- A dependent instruction presented in cycle k+1 stalls until the matching writeback.
- Writeback at edge m clears the last pending write; `busy` drops after edge m.
- With `WB_BYPASS=1`, a dependent instruction issues in the same cycle m as that writeback, giving zero bubble. With `WB_BYPASS=0`, it issues at cycle m+1.
- Combinational path: `wb_*`/`issue_*` → `issue_ready`. There is no path from `issue_valid` to `issue_ready`.
- Reset or flush asserted mid-stream: all pending state is gone after that edge. Instructions presented in the next cycle see no hazard.

## Test plan
- Reset, then issue `rd=5` → `busy=32'h20` next cycle. Then present `rs1=5` → `issue_ready=0` and `stall_cycles` increments each cycle. `wb_rd=5` → with bypass, ready=1 in the same cycle; `busy=0` after the edge.
- Issue three writes to `rd=7` (`MAX_PENDING=3`). A fourth write to x7 with no writeback → `issue_ready=0`. With `wb_rd=7` in the same cycle → accepted and `cnt[7]` stays 3. Three further writebacks → `busy[7]=0`.
- Issue `rd=0` and `rs1=0`/`rs2=0` repeatedly → `issue_ready=1` always, `busy` stays 0.
- `wb_valid` with `wb_rd=9` while `cnt[9]=0` → `underflow_err=1` next cycle. It persists across `flush` and clears on `reset`.
- Pend x3 and x4, then assert `flush` together with `issue_valid` and `wb_rd=3` → `issue_ready=0`, then `busy=0`. The next instruction with `rs1=3`, `rs2=4` issues immediately.
- Hold a stall for 70000 cycles → `stall_cycles` saturates at 16'hFFFF.
